// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: widths, rounding-mode encoding, result constants and the stage-1 record
// shared by the FP32 multiplier back-end. FP_MUL_INEXACT_EN adds the nonzero flag used for nx.
package fp_mul_pkg;

  localparam int EXP_W = 8;
  localparam int FRC_W = 23;
  localparam int SUM_W = EXP_W + 2;
  localparam int E_W   = SUM_W + 2;
  localparam int PRD_W = 2 * (FRC_W + 1);
  localparam int FP_W  = 1 + EXP_W + FRC_W;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [FP_W-2:0] FP_INF  = 31'h7F800000;
  localparam logic [FP_W-2:0] FP_MAXF = 31'h7F7FFFFF;

  localparam logic [E_W-1:0] E_ONE = {{(E_W-1){1'b0}}, 1'b1};
  localparam logic [E_W-1:0] E_MAX = E_W'(EXP_MAX);

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  // e is two extra bits wider than exp_sum so neither +1 can wrap.
  typedef struct packed {
    logic             sign;
    logic [E_W-1:0]   e;
    logic [FRC_W-1:0] mantissa;
    logic             g;
    logic             s;
    logic             zero;
    logic [2:0]       rmode;
`ifdef FP_MUL_INEXACT_EN
    logic             nz;
`endif
  } s1_t;

endpackage

// File: rtl/fp_mul_round_stage_round_dec.sv
// fp_round_dec: combinational round-up decision from rounding mode, sign, lsb, guard and sticky.
module fp_round_dec
  import fp_mul_pkg::*;
(
  input  logic [2:0] r_mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       inc
);

  // Unused encodings fall back to round-to-nearest-even.
  always_comb begin
    inc = 1'b0;
    case (r_mode)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (g | s);
      RUP:     inc = ~sign & (g | s);
      RMM:     inc = g;
      default: inc = g & (s | lsb);
    endcase
  end

endmodule

// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage: normalize / round / pack back-end of the FP32 multiplier, 2-stage valid/ready pipe.
// Define FP_MUL_INEXACT_EN to add the nx (inexact) output.
module fp_mul_round_stage
  import fp_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_Z,
  input  logic [SUM_W-1:0] exp_sum,
  input  logic [PRD_W-1:0] frc_Z_full,
  input  logic             zero_flag,
  input  logic [2:0]       r_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  fp_Z,
  output logic             ovrf,
  output logic             udrf
`ifdef FP_MUL_INEXACT_EN
  ,
  output logic             nx
`endif
);

  logic             en_s;
  s1_t              s1_d, s1_q;
  logic             s1_valid_d, s1_valid_q;
  logic [E_W-1:0]   exp_ext_s;
  logic             inc_s, carry_s;
  logic [FRC_W-1:0] mant_r_s;
  logic [E_W-1:0]   e_r_s;
  logic             ovf_s, udf_s, inf_sel_s;
  logic             out_valid_d, out_valid_q;
  logic             ovrf_d, ovrf_q, udrf_d, udrf_q;
  logic [FP_W-1:0]  fp_z_d, fp_z_q;

  assign en_s      = ~out_valid_q | out_ready;
  assign in_ready  = en_s;
  assign exp_ext_s = {{(E_W-SUM_W){exp_sum[SUM_W-1]}}, exp_sum};

  // Stage 1: capture and normalize the raw Q2.46 product.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (en_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign  = sign_Z;
        s1_d.zero  = zero_flag;
        s1_d.rmode = r_mode;
`ifdef FP_MUL_INEXACT_EN
        s1_d.nz    = |frc_Z_full;
`endif
        if (frc_Z_full[PRD_W-1]) begin
          s1_d.mantissa = frc_Z_full[PRD_W-2 -: FRC_W];
          s1_d.g        = frc_Z_full[PRD_W-2-FRC_W];
          s1_d.s        = |frc_Z_full[PRD_W-3-FRC_W:0];
          s1_d.e        = exp_ext_s + E_ONE;
        end else begin
          s1_d.mantissa = frc_Z_full[PRD_W-3 -: FRC_W];
          s1_d.g        = frc_Z_full[PRD_W-3-FRC_W];
          s1_d.s        = |frc_Z_full[PRD_W-4-FRC_W:0];
          s1_d.e        = exp_ext_s;
        end
      end else begin
        s1_d = s1_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  fp_round_dec u_round_dec (
    .r_mode (s1_q.rmode),
    .sign   (s1_q.sign),
    .lsb    (s1_q.mantissa[0]),
    .g      (s1_q.g),
    .s      (s1_q.s),
    .inc    (inc_s)
  );

  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  assign {carry_s, mant_r_s} = {1'b0, s1_q.mantissa} + {{FRC_W{1'b0}}, inc_s};
  assign e_r_s = s1_q.e + {{(E_W-1){1'b0}}, carry_s};
  assign ovf_s = $signed(e_r_s) >= $signed(E_MAX);
  assign udf_s = $signed(e_r_s) <  $signed(E_ONE);

  // Overflow saturates to infinity only when the mode rounds away from zero for this sign.
  always_comb begin
    inf_sel_s = 1'b1;
    case (s1_q.rmode)
      RTZ:     inf_sel_s = 1'b0;
      RDN:     inf_sel_s = s1_q.sign;
      RUP:     inf_sel_s = ~s1_q.sign;
      default: inf_sel_s = 1'b1;
    endcase
  end

  // Stage 2: round, classify and pack; flags are cleared whenever no result is presented.
  always_comb begin
    out_valid_d = out_valid_q;
    fp_z_d      = fp_z_q;
    ovrf_d      = ovrf_q;
    udrf_d      = udrf_q;
    if (en_s) begin
      out_valid_d = s1_valid_q;
      ovrf_d      = 1'b0;
      udrf_d      = 1'b0;
      if (!s1_valid_q) begin
        fp_z_d = fp_z_q;
      end else if (s1_q.zero) begin
        fp_z_d = {s1_q.sign, {(FP_W-1){1'b0}}};
      end else if (ovf_s) begin
        ovrf_d = 1'b1;
        fp_z_d = {s1_q.sign, (inf_sel_s ? FP_INF : FP_MAXF)};
      end else if (udf_s) begin
        udrf_d = 1'b1;
        fp_z_d = {s1_q.sign, {(FP_W-1){1'b0}}};
      end else begin
        fp_z_d = {s1_q.sign, e_r_s[EXP_W-1:0], mant_r_s};
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fp_z_q      <= '0;
      ovrf_q      <= 1'b0;
      udrf_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      fp_z_q      <= fp_z_d;
      ovrf_q      <= ovrf_d;
      udrf_q      <= udrf_d;
    end
  end

`ifdef FP_MUL_INEXACT_EN
  logic nx_d, nx_q;

  // Inexact: lost bits on the normal path, or any nonzero value that saturated or flushed.
  always_comb begin
    nx_d = nx_q;
    if (en_s) begin
      if (s1_valid_q && !s1_q.zero) begin
        nx_d = (ovf_s || udf_s) ? s1_q.nz : (s1_q.g | s1_q.s);
      end else begin
        nx_d = 1'b0;
      end
    end else begin
      nx_d = nx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nx_q <= 1'b0;
    end else begin
      nx_q <= nx_d;
    end
  end

  assign nx = nx_q;
`endif

  assign out_valid = out_valid_q;
  assign fp_Z      = fp_z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Self-checking bench for fp_mul_round_stage: directed vector table, backpressure and
// mid-flight reset sequences, then randomized traffic against an arithmetic reference model.
module tb_fp_mul_round_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_Z = 1'b0;
  logic [9:0]  exp_sum = 10'd0;
  logic [47:0] frc_Z_full = 48'd0;
  logic        zero_flag = 1'b0;
  logic [2:0]  r_mode = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
`ifdef FP_MUL_INEXACT_EN
  logic        nx;
`endif

  typedef struct {
    logic        sign;
    logic [9:0]  es;
    logic [47:0] frc;
    logic        zero;
    logic [2:0]  rm;
  } vec_t;

  typedef struct {
    logic [31:0] fp;
    logic        ov;
    logic        ud;
    logic        nx;
  } res_t;

  typedef struct {
    vec_t        v;
    logic [31:0] fp;
    logic        ov;
    logic        ud;
  } tv_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic last_rdy = 1'b0;
  tv_t  tab[17];

  always #5 clk = ~clk;

  fp_mul_round_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_Z     (sign_Z),
    .exp_sum    (exp_sum),
    .frc_Z_full (frc_Z_full),
    .zero_flag  (zero_flag),
    .r_mode     (r_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fp_Z       (fp_Z),
    .ovrf       (ovrf),
    .udrf       (udrf)
`ifdef FP_MUL_INEXACT_EN
    ,
    .nx         (nx)
`endif
  );

  // Reference: exact integer quotient/remainder of the product, rounded by comparing the
  // discarded remainder against one half.
  function automatic res_t model(input vec_t v);
    res_t r;
    longint unsigned p, q, rem, half, m;
    int sh, e;
    logic inc, inf;
    r.fp = 32'd0; r.ov = 1'b0; r.ud = 1'b0; r.nx = 1'b0;
    if (v.zero) begin
      r.fp = {v.sign, 31'd0};
      return r;
    end
    p    = 64'(v.frc);
    sh   = v.frc[47] ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    e    = int'($signed(v.es)) + (v.frc[47] ? 1 : 0);
    case (v.rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = v.sign && (rem != 64'd0);
      3'd3:    inc = !v.sign && (rem != 64'd0);
      3'd4:    inc = (rem >= half);
      default: inc = (rem > half) || ((rem == half) && q[0]);
    endcase
    m = (q & 64'h7FFFFF) + 64'(inc);
    if (m == 64'h800000) begin
      m = 64'd0;
      e = e + 1;
    end
    if (e >= 255) begin
      r.ov = 1'b1;
      inf  = (v.rm == 3'd1) ? 1'b0 : (v.rm == 3'd2) ? v.sign : (v.rm == 3'd3) ? !v.sign : 1'b1;
      r.fp = {v.sign, (inf ? 31'h7F800000 : 31'h7F7FFFFF)};
      r.nx = (p != 64'd0);
    end else if (e <= 0) begin
      r.ud = 1'b1;
      r.fp = {v.sign, 31'd0};
      r.nx = (p != 64'd0);
    end else begin
      r.fp = {v.sign, 8'(e), 23'(m)};
      r.nx = (rem != 64'd0);
    end
    return r;
  endfunction

  function automatic tv_t mk(input logic s, input logic [9:0] es, input logic [47:0] frc,
                             input logic z, input logic [2:0] rm, input logic [31:0] fp,
                             input logic ov, input logic ud);
    tv_t t;
    t.v.sign = s; t.v.es = es; t.v.frc = frc; t.v.zero = z; t.v.rm = rm;
    t.fp = fp; t.ov = ov; t.ud = ud;
    return t;
  endfunction

  function automatic res_t tab_res(input tv_t t);
    res_t r;
    r    = model(t.v);
    r.fp = t.fp;
    r.ov = t.ov;
    r.ud = t.ud;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic mon();
    res_t r;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", fp_Z);
      end else begin
        r = sb.pop_front();
        chk("result_fp", fp_Z, r.fp);
        chk("result_ovrf", 32'(ovrf), 32'(r.ov));
        chk("result_udrf", 32'(udrf), 32'(r.ud));
`ifdef FP_MUL_INEXACT_EN
        chk("result_nx", 32'(nx), 32'(r.nx));
`endif
      end
    end else if (!rst && !out_valid) begin
      chk("idle_ovrf", 32'(ovrf), 32'd0);
      chk("idle_udrf", 32'(udrf), 32'd0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    last_rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    sign_Z     = v.sign;
    exp_sum    = v.es;
    frc_Z_full = v.frc;
    zero_flag  = v.zero;
    r_mode     = v.rm;
  endtask

  task automatic send(input vec_t v, input res_t ex, input logic force_rel);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    drive(v);
    while (!done) begin
      step();
      if (last_rdy) begin
        sb.push_back(ex);
        done = 1'b1;
      end else begin
        n++;
        if (force_rel) out_ready = 1'b1;
        if (n > 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout actual=stalled expected=accepted");
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tab[0]  = mk(1'b0, 10'd127, 48'h900000000000, 1'b0, 3'd0, 32'h40100000, 1'b0, 1'b0);
    tab[1]  = mk(1'b0, 10'd127, 48'h400000400000, 1'b0, 3'd0, 32'h3F800000, 1'b0, 1'b0);
    tab[2]  = mk(1'b0, 10'd127, 48'h400000400000, 1'b0, 3'd3, 32'h3F800001, 1'b0, 1'b0);
    tab[3]  = mk(1'b1, 10'd127, 48'h400000400000, 1'b0, 3'd2, 32'hBF800001, 1'b0, 1'b0);
    tab[4]  = mk(1'b0, 10'd127, 48'h400000400000, 1'b0, 3'd4, 32'h3F800001, 1'b0, 1'b0);
    tab[5]  = mk(1'b1, 10'd127, 48'h400000400000, 1'b0, 3'd1, 32'hBF800000, 1'b0, 1'b0);
    tab[6]  = mk(1'b0, 10'd300, 48'h400000000000, 1'b0, 3'd0, 32'h7F800000, 1'b1, 1'b0);
    tab[7]  = mk(1'b0, 10'd300, 48'h400000000000, 1'b0, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0);
    tab[8]  = mk(1'b0, 10'h3FB, 48'h400000000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1);
    tab[9]  = mk(1'b1, 10'd127, 48'h900000000000, 1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0);
    tab[10] = mk(1'b0, 10'd254, 48'h400000000000, 1'b0, 3'd0, 32'h7F000000, 1'b0, 1'b0);
    tab[11] = mk(1'b1, 10'd254, 48'h800000000000, 1'b0, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0);
    tab[12] = mk(1'b0, 10'd0,   48'h400000000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1);
    tab[13] = mk(1'b0, 10'd0,   48'h800000000000, 1'b0, 3'd0, 32'h00800000, 1'b0, 1'b0);
    tab[14] = mk(1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 3'd0, 32'h40000000, 1'b0, 1'b0);
    tab[15] = mk(1'b0, 10'd254, 48'h7FFFFFC00000, 1'b0, 3'd5, 32'h7F800000, 1'b1, 1'b0);
    tab[16] = mk(1'b1, 10'h3FB, 48'h400000000000, 1'b0, 3'd2, 32'h80000000, 1'b0, 1'b1);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_fp_Z", fp_Z, 32'd0);
    chk("reset_ovrf", 32'(ovrf), 32'd0);
    chk("reset_udrf", 32'(udrf), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // Directed vectors, streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(tab[i].v, tab_res(tab[i]), 1'b0);
    drain();

    // Backpressure: two items fill the pipe, the third must wait with the output held
    out_ready = 1'b0;
    send(tab[0].v, tab_res(tab[0]), 1'b0);
    send(tab[1].v, tab_res(tab[1]), 1'b0);
    drive(tab[2].v);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", 32'(last_rdy), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_fp_Z", fp_Z, tab[0].fp);
    end
    out_ready = 1'b1;
    send(tab[2].v, tab_res(tab[2]), 1'b0);
    drain();

    // Reset with two items in flight: nothing may emerge afterwards
    out_ready = 1'b0;
    send(tab[3].v, tab_res(tab[3]), 1'b0);
    send(tab[6].v, tab_res(tab[6]), 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ovrf", 32'(ovrf), 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      v.sign = 1'($urandom_range(0, 1));
      v.zero = ($urandom_range(0, 9) == 0);
      v.rm   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       v.es = 10'($urandom);
        1:       v.es = 10'(250 + $urandom_range(0, 10));
        2:       v.es = 10'($urandom_range(0, 6)) - 10'd3;
        default: v.es = 10'(120 + $urandom_range(0, 15));
      endcase
      v.frc = {16'($urandom), $urandom};
      case ($urandom_range(0, 3))
        0: v.frc[47] = 1'b1;
        1: begin v.frc[47] = 1'b0; v.frc[46] = 1'b1; end
        2: begin v.frc[47] = 1'b1; v.frc[22:0] = 23'd0; end
        default: ;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) step();
      send(v, model(v), 1'b1);
    end
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
